b16_sram_ctrl: RTL and testbench

//  Registered controller for the external 16-bit async SRAM on the eval board.

---
 rtl/b16_sram_ctrl.sv | 136 +++++++++++++
 tb/tb_b16_sram_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/b16_sram_ctrl.sv
// b16_sram_ctrl: registered controller for the board's external 16-bit async SRAM.
// Arbitrates CPU and USB DMA accesses (DMA first), drives registered strobes with a
// WAIT-parameterised width and returns read data plus a one-cycle completion pulse.
module b16_sram_ctrl #(
  parameter int l    = 16,
  parameter int WAIT = 1
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [l-1:0] cpu_addr,
  input  logic         cpu_r,
  input  logic [1:0]   cpu_w,
  input  logic [l-1:0] cpu_din,
  output logic         cpu_ready,
  input  logic [l-1:0] dma_addr,
  input  logic         dma_reqr,
  input  logic         dma_reqw,
  input  logic [l-1:0] dma_din,
  output logic         dma_ack,
  output logic [l-1:0] rdata,
  output logic [l-1:0] a,
  inout  wire  [l-1:0] d,
  output logic         wr_b,
  output logic         rd_b,
  output logic         ble_b,
  output logic         bhe_b
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         op_dma_q, op_dma_d;
  logic         op_wr_q, op_wr_d;
  logic [1:0]   op_en_q, op_en_d;
  logic [l-1:0] op_data_q, op_data_d;
  logic [l-1:0] a_d;
  logic         d_oe;
  logic         done;

  assign d = d_oe ? op_data_q : 'z;

  // Next-state, grant arbitration and op decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_dma_d  = op_dma_q;
    op_wr_d   = op_wr_q;
    op_en_d   = op_en_q;
    op_data_d = op_data_q;
    a_d       = a;
    case (state_q)
      IDLE: begin
        if (dma_reqr || dma_reqw) begin
          op_dma_d  = 1'b1;
          op_wr_d   = dma_reqw;
          op_en_d   = 2'b11;
          op_data_d = dma_din;
          a_d       = {1'b0, dma_addr[l-1:1]};
          state_d   = SETUP;
        end else if (cpu_r || (|cpu_w)) begin
          op_dma_d  = 1'b0;
          op_wr_d   = |cpu_w;
          op_en_d   = (|cpu_w) ? cpu_w : 2'b11;
          op_data_d = cpu_din;
          a_d       = {1'b0, cpu_addr[l-1:1]};
          state_d   = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = WAIT_CNT;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 4'd1;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign done = (state_q == STROBE) && (state_d == HOLD);

  // State, counter, op registers and SRAM address.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_dma_q  <= 1'b0;
      op_wr_q   <= 1'b0;
      op_en_q   <= '0;
      op_data_q <= '0;
      a         <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_dma_q  <= op_dma_d;
      op_wr_q   <= op_wr_d;
      op_en_q   <= op_en_d;
      op_data_q <= op_data_d;
      a         <= a_d;
    end
  end

  // Strobes, bus enable and completion pulses are registered from the next state,
  // so they change in the same cycle as the state they belong to.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rd_b      <= 1'b1;
      wr_b      <= 1'b1;
      ble_b     <= 1'b1;
      bhe_b     <= 1'b1;
      d_oe      <= 1'b0;
      cpu_ready <= 1'b0;
      dma_ack   <= 1'b0;
    end else begin
      rd_b      <= !((state_d == STROBE) && !op_wr_d);
      wr_b      <= !((state_d == STROBE) && op_wr_d);
      ble_b     <= !((state_d == STROBE) && op_en_d[0]);
      bhe_b     <= !((state_d == STROBE) && op_en_d[1]);
      d_oe      <= op_wr_d && (state_d != IDLE);
      cpu_ready <= done && !op_dma_q;
      dma_ack   <= done && op_dma_q;
    end
  end

  // Read data capture at the edge that leaves STROBE; writes leave it untouched.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)              rdata <= '0;
    else if (done && !op_wr_q) rdata <= d;
  end

endmodule

// File: tb/tb_b16_sram_ctrl.sv
// Directed bench for b16_sram_ctrl: WAIT=1 instance for arbitration, strobe, bus and
// reset behaviour; WAIT=0 instance for back-to-back read timing.
module tb_b16_sram_ctrl;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  logic [15:0] mem [0:255];

  // WAIT=1 instance
  logic [15:0] cpu_addr0 = '0, cpu_din0 = '0, dma_addr0 = '0, dma_din0 = '0;
  logic        cpu_r0 = 1'b0, dma_reqr0 = 1'b0, dma_reqw0 = 1'b0;
  logic [1:0]  cpu_w0 = '0;
  logic        cpu_ready0, dma_ack0, wr0_b, rd0_b, ble0_b, bhe0_b;
  logic [15:0] rdata0, a0, mem_rd0;
  wire  [15:0] d0;
  logic        probe0 = 1'b0;

  assign mem_rd0 = mem[a0[7:0]];
  assign d0 = (!rd0_b) ? mem_rd0 : 16'hzzzz;
  assign d0 = probe0 ? 16'h0000 : 16'hzzzz;

  b16_sram_ctrl #(.l(16), .WAIT(1)) u0 (
    .clk(clk), .nreset(nreset),
    .cpu_addr(cpu_addr0), .cpu_r(cpu_r0), .cpu_w(cpu_w0), .cpu_din(cpu_din0),
    .cpu_ready(cpu_ready0),
    .dma_addr(dma_addr0), .dma_reqr(dma_reqr0), .dma_reqw(dma_reqw0), .dma_din(dma_din0),
    .dma_ack(dma_ack0),
    .rdata(rdata0), .a(a0), .d(d0),
    .wr_b(wr0_b), .rd_b(rd0_b), .ble_b(ble0_b), .bhe_b(bhe0_b)
  );

  // WAIT=0 instance
  logic [15:0] cpu_addr1 = '0, cpu_din1 = '0, dma_addr1 = '0, dma_din1 = '0;
  logic        cpu_r1 = 1'b0, dma_reqr1 = 1'b0, dma_reqw1 = 1'b0;
  logic [1:0]  cpu_w1 = '0;
  logic        cpu_ready1, dma_ack1, wr1_b, rd1_b, ble1_b, bhe1_b;
  logic [15:0] rdata1, a1, mem_rd1;
  wire  [15:0] d1;

  assign mem_rd1 = mem[a1[7:0]];
  assign d1 = (!rd1_b) ? mem_rd1 : 16'hzzzz;

  b16_sram_ctrl #(.l(16), .WAIT(0)) u1 (
    .clk(clk), .nreset(nreset),
    .cpu_addr(cpu_addr1), .cpu_r(cpu_r1), .cpu_w(cpu_w1), .cpu_din(cpu_din1),
    .cpu_ready(cpu_ready1),
    .dma_addr(dma_addr1), .dma_reqr(dma_reqr1), .dma_reqw(dma_reqw1), .dma_din(dma_din1),
    .dma_ack(dma_ack1),
    .rdata(rdata1), .a(a1), .d(d1),
    .wr_b(wr1_b), .rd_b(rd1_b), .ble_b(ble1_b), .bhe_b(bhe1_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic strb(input string tag, input logic rd, input logic wr,
                      input logic ble, input logic bhe);
    chk({tag, " rd_b"}, 32'(rd0_b), 32'(rd));
    chk({tag, " wr_b"}, 32'(wr0_b), 32'(wr));
    chk({tag, " ble_b"}, 32'(ble0_b), 32'(ble));
    chk({tag, " bhe_b"}, 32'(bhe0_b), 32'(bhe));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_rd1, exp_rdy1;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h92] = 16'hBEEF;
    mem[8'h08] = 16'h1234;
    mem[8'h01] = 16'hA5A5;

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    probe0 = 1'b1;
    #1;
    strb("reset", 1, 1, 1, 1);
    chk("reset a", 32'(a0), 32'h0);
    chk("reset rdata", 32'(rdata0), 32'h0);
    chk("reset cpu_ready", 32'(cpu_ready0), 32'h0);
    chk("reset dma_ack", 32'(dma_ack0), 32'h0);
    chk("reset d_z", 32'(d0), 32'h0);
    probe0 = 1'b0;
    nreset = 1'b1;
    tick;

    // Test 1: CPU read 0x0124
    cpu_addr0 = 16'h0124; cpu_r0 = 1'b1;
    tick;
    chk("t1 setup a", 32'(a0), 32'h0092);
    strb("t1 setup", 1, 1, 1, 1);
    tick;
    strb("t1 strobe1", 0, 1, 0, 0);
    tick;
    strb("t1 strobe2", 0, 1, 0, 0);
    chk("t1 strobe2 ready", 32'(cpu_ready0), 32'h0);
    tick;
    strb("t1 hold", 1, 1, 1, 1);
    chk("t1 hold ready", 32'(cpu_ready0), 32'h1);
    chk("t1 hold ack", 32'(dma_ack0), 32'h0);
    chk("t1 rdata", 32'(rdata0), 32'hBEEF);
    cpu_r0 = 1'b0;
    tick;
    chk("t1 idle ready", 32'(cpu_ready0), 32'h0);

    // Test 2: CPU high-byte write 0x12AB to 0x0200
    cpu_addr0 = 16'h0200; cpu_w0 = 2'b10; cpu_din0 = 16'h12AB;
    tick;
    chk("t2 setup a", 32'(a0), 32'h0100);
    chk("t2 setup d", 32'(d0), 32'h12AB);
    strb("t2 setup", 1, 1, 1, 1);
    tick;
    strb("t2 strobe1", 1, 0, 1, 0);
    chk("t2 strobe1 d", 32'(d0), 32'h12AB);
    tick;
    strb("t2 strobe2", 1, 0, 1, 0);
    chk("t2 strobe2 d", 32'(d0), 32'h12AB);
    tick;
    strb("t2 hold", 1, 1, 1, 1);
    chk("t2 hold d", 32'(d0), 32'h12AB);
    chk("t2 hold ready", 32'(cpu_ready0), 32'h1);
    chk("t2 rdata kept", 32'(rdata0), 32'hBEEF);
    cpu_w0 = 2'b00;
    tick;
    probe0 = 1'b1;
    #1;
    chk("t2 idle d_z", 32'(d0), 32'h0);
    chk("t2 idle ready", 32'(cpu_ready0), 32'h0);
    probe0 = 1'b0;

    // Test 3: CPU read and DMA write on the same edge
    cpu_addr0 = 16'h0010; cpu_r0 = 1'b1;
    dma_addr0 = 16'h0040; dma_din0 = 16'h5555; dma_reqw0 = 1'b1;
    tick;
    chk("t3 dma setup a", 32'(a0), 32'h0020);
    chk("t3 dma setup d", 32'(d0), 32'h5555);
    tick;
    strb("t3 dma strobe1", 1, 0, 0, 0);
    tick;
    strb("t3 dma strobe2", 1, 0, 0, 0);
    tick;
    chk("t3 dma ack", 32'(dma_ack0), 32'h1);
    chk("t3 no cpu ready", 32'(cpu_ready0), 32'h0);
    dma_reqw0 = 1'b0;
    tick;
    probe0 = 1'b1;
    #1;
    chk("t3 idle d_z", 32'(d0), 32'h0);
    probe0 = 1'b0;
    tick;
    chk("t3 cpu setup a", 32'(a0), 32'h0008);
    tick;
    strb("t3 cpu strobe1", 0, 1, 0, 0);
    tick;
    strb("t3 cpu strobe2", 0, 1, 0, 0);
    tick;
    chk("t3 cpu ready", 32'(cpu_ready0), 32'h1);
    chk("t3 cpu no ack", 32'(dma_ack0), 32'h0);
    chk("t3 rdata", 32'(rdata0), 32'h1234);
    cpu_r0 = 1'b0;
    tick;

    // Test 4: DMA read raised during a CPU low-byte write's STROBE
    cpu_addr0 = 16'h0301; cpu_w0 = 2'b01; cpu_din0 = 16'h00CD;
    tick;
    chk("t4 setup a", 32'(a0), 32'h0180);
    tick;
    dma_addr0 = 16'h0002; dma_reqr0 = 1'b1;
    strb("t4 strobe1", 1, 0, 0, 1);
    tick;
    strb("t4 strobe2", 1, 0, 0, 1);
    chk("t4 strobe2 a", 32'(a0), 32'h0180);
    chk("t4 strobe2 d", 32'(d0), 32'h00CD);
    tick;
    chk("t4 cpu ready", 32'(cpu_ready0), 32'h1);
    chk("t4 no ack yet", 32'(dma_ack0), 32'h0);
    cpu_w0 = 2'b00;
    tick;
    chk("t4 idle a", 32'(a0), 32'h0180);
    strb("t4 idle", 1, 1, 1, 1);
    tick;
    chk("t4 dma setup a", 32'(a0), 32'h0001);
    tick;
    strb("t4 dma strobe1", 0, 1, 0, 0);
    tick;
    tick;
    chk("t4 dma ack", 32'(dma_ack0), 32'h1);
    chk("t4 dma rdata", 32'(rdata0), 32'hA5A5);
    dma_reqr0 = 1'b0;
    tick;

    // Test 5: asynchronous reset during a write's STROBE
    cpu_addr0 = 16'h0400; cpu_w0 = 2'b11; cpu_din0 = 16'hFFFF;
    tick;
    tick;
    strb("t5 strobe", 1, 0, 0, 0);
    #2;
    probe0 = 1'b1;
    nreset = 1'b0;
    #1;
    strb("t5 async", 1, 1, 1, 1);
    chk("t5 async d_z", 32'(d0), 32'h0);
    chk("t5 async a", 32'(a0), 32'h0);
    chk("t5 async rdata", 32'(rdata0), 32'h0);
    tick;
    tick;
    chk("t5 no ready", 32'(cpu_ready0), 32'h0);
    cpu_w0 = 2'b00;
    nreset = 1'b1;
    tick;
    tick;
    chk("t5 idle ready", 32'(cpu_ready0), 32'h0);
    strb("t5 idle", 1, 1, 1, 1);
    chk("t5 idle d_z", 32'(d0), 32'h0);
    probe0 = 1'b0;

    // Test 6: WAIT=0, back-to-back CPU reads
    exp_rd1  = 8'b1101_1101;
    exp_rdy1 = 8'b0100_0100;
    cpu_addr1 = 16'h0124; cpu_r1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick;
      chk($sformatf("t6 cyc%0d rd_b", c + 1), 32'(rd1_b), 32'(exp_rd1[c]));
      chk($sformatf("t6 cyc%0d ready", c + 1), 32'(cpu_ready1), 32'(exp_rdy1[c]));
    end
    cpu_r1 = 1'b0;
    chk("t6 rdata", 32'(rdata1), 32'hBEEF);
    chk("t6 no ack", 32'(dma_ack1), 32'h0);
    tick;
    tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
